wb_result_queue: RTL and testbench
==================================

// Module: wb_result_queue
// PURPOSE
//  FU-side producer of the writeback handshake. Buffers results from IN_SIZE
//  multi-cycle producers (mul/div) and presents them oldest-first on OUT_SIZE
//  writeback slots. Each slot holds its result until the writeback stage
//  accepts it. Entries younger than a redirect are killed, so flushed
//  results never reach the writeback bus.
// PARAMETERS
//  IN_SIZE   2   producer lanes that can enqueue per cycle
//  OUT_SIZE  1   writeback slots driven per cycle (1 or 2)
//  DEPTH     4   queue entries, power of 2, >= IN_SIZE
//  ROB_W     6   rob index width; MSB is the wrap (dir) bit
//  PREG_W    6   physical destination register width
//  XLEN      32  result width
// PORTS
//  clk            in   1               clock
//  rst            in   1               synchronous, active-high reset
//  in_valid       in   IN_SIZE         lane i carries a result
//  in_ready       out  1               queue can take IN_SIZE results this cycle
//  in_rob_idx     in   IN_SIZE*ROB_W   rob index per lane
//  in_rd          in   IN_SIZE*PREG_W  destination preg per lane
//  in_res         in   IN_SIZE*XLEN    result data per lane
//  wb_en          out  OUT_SIZE        slot k presents a live result (datas.en)
//  wb_rob_idx     out  OUT_SIZE*ROB_W  slot rob index
//  wb_rd          out  OUT_SIZE*PREG_W slot destination preg
//  wb_res         out  OUT_SIZE*XLEN   slot result
//  wb_valid       in   OUT_SIZE        writeback accepts slot k this cycle
//  flush          in   1               redirect
//  flush_rob_idx  in   ROB_W           redirect point; strictly younger entries die
// BEHAVIOUR
//  - Circular buffer: head/tail pointers, log2(DEPTH)+1 bits each with a wrap
//    bit. count = tail-head, range 0..DEPTH. Per entry: occupied, live,
//    rob_idx, rd, res.
//  - Reset: head=tail=0, all entries free. Outputs next cycle: in_ready=1,
//    wb_en=0, and wb_rob_idx/wb_rd/wb_res all zero.
//  - in_ready = (DEPTH - count) >= IN_SIZE, from registered count only; same-
//    cycle pops do not raise it. in_valid lanes are ignored while in_ready=0.
//  - Enqueue: valid lanes are compacted in lane order (lane 0 oldest) starting
//    at tail. tail advances by popcount(in_valid). Data is visible on the
//    outputs the next cycle (1-cycle latency).
//  - Slot k shows entry head+k when it is occupied. wb_en[k] = live. Empty
//    slots drive wb_en=0 and zero data. Outputs are combinational from
//    registers only; no flush->wb_en path.
//  - Pop is in order. Slot k pops iff all of the following hold:
//    occupied; (!live or wb_valid[k]); every slot j<k pops.
//    Dead entries drain without wb_valid. head advances by the pop count.
//  - Age: younger(a,b) = (a.dir != b.dir) ^ (a.idx > b.idx).
//  - Flush cycle: occupied entries with younger(rob, flush_rob_idx) get live=0
//    next cycle. Same-cycle inputs that are younger are not enqueued. A live
//    entry accepted by wb_valid in the flush cycle still pops normally.
//  - Full (count=DEPTH) with no pops: state holds and in_ready=0. When empty,
//    wb_en=0 regardless of wb_valid.
//  - Pointer wrap is transparent to ordering.
//  - rd==0 results are queued and emitted; write-enable is the consumer's job.
//  - rst at any point, including mid-drain or mid-flush, discards all entries.
// TESTING
//  1. Reset -> next cycle in_ready=1, wb_en=0, outputs zero.
//  2. Enqueue lane0 {rob=5, rd=3, res=0xDEAD}, wb_valid=1 -> next cycle
//     wb_en[0]=1 with those values; cycle after, wb_en=0.
//  3. wb_valid=0, 2 results/cycle, DEPTH=4 -> in_ready=0 after 2 cycles and
//     extra inputs are dropped. Then wb_valid=1 -> 4 results in enqueue order.
//  4. Queue rob 3,4,7, then flush rob=4 -> 3 and 4 emitted with wb_en=1;
//     7 drains with wb_en=0.
//  5. Entry {dir=1, idx=1}, flush {dir=0, idx=30} -> entry killed. After 3
//     pointer wraps, ordering is unchanged.
//  6. OUT_SIZE=2, two live entries, wb_valid=2'b10 -> no pop; 2'b11 -> both pop.
//  7. rst during a drain with 3 entries -> next cycle empty and in_ready=1.

Source files
------------

// File: rtl/wb_result_queue_if.sv
// Writeback result queue bundle: producer enqueue lanes, writeback slots and redirect.
// The slave modport is the queue's view; the master modport is the environment's view.
interface wb_result_queue_if #(
   parameter int IN_SIZE  = 2,
   parameter int OUT_SIZE = 1,
   parameter int ROB_W    = 6,
   parameter int PREG_W   = 6,
   parameter int XLEN     = 32
);
   logic [IN_SIZE-1:0]         in_valid;
   logic                       in_ready;
   logic [IN_SIZE*ROB_W-1:0]   in_rob_idx;
   logic [IN_SIZE*PREG_W-1:0]  in_rd;
   logic [IN_SIZE*XLEN-1:0]    in_res;
   logic [OUT_SIZE-1:0]        wb_en;
   logic [OUT_SIZE*ROB_W-1:0]  wb_rob_idx;
   logic [OUT_SIZE*PREG_W-1:0] wb_rd;
   logic [OUT_SIZE*XLEN-1:0]   wb_res;
   logic [OUT_SIZE-1:0]        wb_valid;
   logic                       flush;
   logic [ROB_W-1:0]           flush_rob_idx;

   modport slave (
      input  in_valid, in_rob_idx, in_rd, in_res, wb_valid, flush, flush_rob_idx,
      output in_ready, wb_en, wb_rob_idx, wb_rd, wb_res
   );

   modport master (
      output in_valid, in_rob_idx, in_rd, in_res, wb_valid, flush, flush_rob_idx,
      input  in_ready, wb_en, wb_rob_idx, wb_rd, wb_res
   );
endinterface

// File: rtl/wb_result_queue.sv
// In-order circular queue buffering multi-cycle FU results for the writeback bus.
// Entries younger than a redirect are marked dead and drain without a handshake.
module wb_result_queue #(
   parameter int IN_SIZE  = 2,
   parameter int OUT_SIZE = 1,
   parameter int DEPTH    = 4,
   parameter int ROB_W    = 6,
   parameter int PREG_W   = 6,
   parameter int XLEN     = 32
) (
   input logic clk,
   input logic rst,
   wb_result_queue_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0]  head_p1, tail_p1, count;
   logic [DEPTH-1:0]  vld_p1, live_p1;
   logic [ROB_W-1:0]  rob_p1 [DEPTH];
   logic [PREG_W-1:0] rd_p1  [DEPTH];
   logic [XLEN-1:0]   res_p1 [DEPTH];

   logic [OUT_SIZE-1:0] pop_go;
   logic [IDX_W-1:0]    pop_slot [OUT_SIZE];
   logic [PTR_W-1:0]    pop_cnt;
   logic                chain;

   logic [IN_SIZE-1:0]  enq_we;
   logic [IDX_W-1:0]    enq_slot [IN_SIZE];
   logic [PTR_W-1:0]    enq_cnt;

   // The MSB is the wrap bit; a differing wrap bit inverts the index comparison.
   function automatic logic younger(input logic [ROB_W-1:0] a, input logic [ROB_W-1:0] b);
      return (a[ROB_W-1] != b[ROB_W-1]) ^ (a[ROB_W-2:0] > b[ROB_W-2:0]);
   endfunction

   assign count        = tail_p1 - head_p1;
   assign bus.in_ready = (int'(count) + IN_SIZE) <= DEPTH;

   always_comb begin
      bus.wb_en      = '0;
      bus.wb_rob_idx = '0;
      bus.wb_rd      = '0;
      bus.wb_res     = '0;
      pop_go         = '0;
      pop_cnt        = '0;
      chain          = 1'b1;
      for (int k = 0; k < OUT_SIZE; k++) begin
         pop_slot[k] = head_p1[IDX_W-1:0] + IDX_W'(k);
         if (vld_p1[pop_slot[k]]) begin
            bus.wb_en[k]                     = live_p1[pop_slot[k]];
            bus.wb_rob_idx[k*ROB_W +: ROB_W] = rob_p1[pop_slot[k]];
            bus.wb_rd[k*PREG_W +: PREG_W]    = rd_p1[pop_slot[k]];
            bus.wb_res[k*XLEN +: XLEN]       = res_p1[pop_slot[k]];
         end
         // Pops form a prefix: a stalled slot blocks every slot behind it.
         chain     = chain & vld_p1[pop_slot[k]] & (~live_p1[pop_slot[k]] | bus.wb_valid[k]);
         pop_go[k] = chain;
         pop_cnt   = pop_cnt + {{(PTR_W-1){1'b0}}, chain};
      end
   end

   always_comb begin
      enq_we  = '0;
      enq_cnt = '0;
      for (int i = 0; i < IN_SIZE; i++) begin
         enq_slot[i] = '0;
         if (bus.in_ready && bus.in_valid[i] &&
             !(bus.flush && younger(bus.in_rob_idx[i*ROB_W +: ROB_W], bus.flush_rob_idx))) begin
            enq_we[i]   = 1'b1;
            enq_slot[i] = tail_p1[IDX_W-1:0] + enq_cnt[IDX_W-1:0];
            enq_cnt     = enq_cnt + PTR_W'(1);
         end
      end
   end

   // Control state: pointers, occupancy and liveness.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_p1 <= '0;
         tail_p1 <= '0;
         vld_p1  <= '0;
         live_p1 <= '0;
      end else begin
         head_p1 <= head_p1 + pop_cnt;
         tail_p1 <= tail_p1 + enq_cnt;
         for (int d = 0; d < DEPTH; d++) begin
            if (bus.flush && vld_p1[d] && younger(rob_p1[d], bus.flush_rob_idx))
               live_p1[d] <= 1'b0;
         end
         for (int k = 0; k < OUT_SIZE; k++) begin
            if (pop_go[k])
               vld_p1[pop_slot[k]] <= 1'b0;
         end
         for (int i = 0; i < IN_SIZE; i++) begin
            if (enq_we[i]) begin
               vld_p1[enq_slot[i]]  <= 1'b1;
               live_p1[enq_slot[i]] <= 1'b1;
            end
         end
      end
   end

   // Payload storage; never read unless the matching occupancy bit is set.
   always_ff @(posedge clk) begin
      for (int i = 0; i < IN_SIZE; i++) begin
         if (enq_we[i]) begin
            rob_p1[enq_slot[i]] <= bus.in_rob_idx[i*ROB_W +: ROB_W];
            rd_p1[enq_slot[i]]  <= bus.in_rd[i*PREG_W +: PREG_W];
            res_p1[enq_slot[i]] <= bus.in_res[i*XLEN +: XLEN];
         end
      end
   end
endmodule

// File: tb/tb_wb_result_queue.sv
// Directed bench for wb_result_queue: one OUT_SIZE=1 and one OUT_SIZE=2 instance.
module tb_wb_result_queue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_result_queue_if #(.IN_SIZE(2), .OUT_SIZE(1), .ROB_W(6), .PREG_W(6), .XLEN(32)) bus1 ();
   wb_result_queue_if #(.IN_SIZE(2), .OUT_SIZE(2), .ROB_W(6), .PREG_W(6), .XLEN(32)) bus2 ();

   wb_result_queue #(.IN_SIZE(2), .OUT_SIZE(1), .DEPTH(4), .ROB_W(6), .PREG_W(6), .XLEN(32))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));
   wb_result_queue #(.IN_SIZE(2), .OUT_SIZE(2), .DEPTH(4), .ROB_W(6), .PREG_W(6), .XLEN(32))
      dut2 (.clk(clk), .rst(rst), .bus(bus2));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lane1(input int i, input logic [5:0] rob, input logic [5:0] rd, input logic [31:0] res);
      bus1.in_rob_idx[i*6 +: 6] = rob;
      bus1.in_rd[i*6 +: 6]      = rd;
      bus1.in_res[i*32 +: 32]   = res;
   endtask

   task automatic lane2(input int i, input logic [5:0] rob, input logic [5:0] rd, input logic [31:0] res);
      bus2.in_rob_idx[i*6 +: 6] = rob;
      bus2.in_rd[i*6 +: 6]      = rd;
      bus2.in_res[i*32 +: 32]   = res;
   endtask

   initial begin
      bus1.in_valid = '0; bus1.in_rob_idx = '0; bus1.in_rd = '0; bus1.in_res = '0;
      bus1.wb_valid = '0; bus1.flush = 1'b0; bus1.flush_rob_idx = '0;
      bus2.in_valid = '0; bus2.in_rob_idx = '0; bus2.in_rd = '0; bus2.in_res = '0;
      bus2.wb_valid = '0; bus2.flush = 1'b0; bus2.flush_rob_idx = '0;

      // 1. reset state
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("rst_in_ready", 64'(bus1.in_ready), 64'd1);
      check("rst_wb_en", 64'(bus1.wb_en), 64'd0);
      check("rst_rob", 64'(bus1.wb_rob_idx), 64'd0);
      check("rst_rd", 64'(bus1.wb_rd), 64'd0);
      check("rst_res", 64'(bus1.wb_res), 64'd0);
      check("rst_wb_en2", 64'(bus2.wb_en), 64'd0);

      // 2. single result, accepted immediately
      bus1.in_valid = 2'b01;
      lane1(0, 6'd5, 6'd3, 32'hDEAD);
      bus1.wb_valid = 1'b1;
      tick();
      bus1.in_valid = 2'b00;
      check("t2_en", 64'(bus1.wb_en), 64'd1);
      check("t2_rob", 64'(bus1.wb_rob_idx), 64'd5);
      check("t2_rd", 64'(bus1.wb_rd), 64'd3);
      check("t2_res", 64'(bus1.wb_res), 64'hDEAD);
      tick();
      check("t2_en_after", 64'(bus1.wb_en), 64'd0);
      check("t2_res_after", 64'(bus1.wb_res), 64'd0);

      // 3. fill to full with no acceptance; extra inputs dropped
      bus1.wb_valid = 1'b0;
      bus1.in_valid = 2'b11;
      lane1(0, 6'd10, 6'd1, 32'h100);
      lane1(1, 6'd11, 6'd2, 32'h101);
      tick();
      check("t3_ready_half", 64'(bus1.in_ready), 64'd1);
      lane1(0, 6'd12, 6'd3, 32'h102);
      lane1(1, 6'd13, 6'd4, 32'h103);
      tick();
      check("t3_ready_full", 64'(bus1.in_ready), 64'd0);
      lane1(0, 6'd14, 6'd5, 32'h104);
      lane1(1, 6'd15, 6'd6, 32'h105);
      tick();
      bus1.in_valid = 2'b00;
      check("t3_hold_ready", 64'(bus1.in_ready), 64'd0);
      check("t3_hold_rob", 64'(bus1.wb_rob_idx), 64'd10);
      bus1.wb_valid = 1'b1;
      for (int j = 0; j < 4; j++) begin
         check("t3_drain_en", 64'(bus1.wb_en), 64'd1);
         check("t3_drain_rob", 64'(bus1.wb_rob_idx), 64'(10 + j));
         check("t3_drain_res", 64'(bus1.wb_res), 64'(32'h100 + j));
         tick();
      end
      check("t3_empty_en", 64'(bus1.wb_en), 64'd0);
      check("t3_empty_ready", 64'(bus1.in_ready), 64'd1);

      // 4. flush kills strictly younger entries only
      bus1.wb_valid = 1'b0;
      bus1.in_valid = 2'b11;
      lane1(0, 6'd3, 6'd7, 32'h33);
      lane1(1, 6'd4, 6'd8, 32'h44);
      tick();
      bus1.in_valid = 2'b01;
      lane1(0, 6'd7, 6'd9, 32'h77);
      tick();
      bus1.in_valid = 2'b00;
      bus1.flush = 1'b1;
      bus1.flush_rob_idx = 6'd4;
      tick();
      bus1.flush = 1'b0;
      bus1.wb_valid = 1'b1;
      check("t4_rob3_en", 64'(bus1.wb_en), 64'd1);
      check("t4_rob3", 64'(bus1.wb_rob_idx), 64'd3);
      tick();
      check("t4_rob4_en", 64'(bus1.wb_en), 64'd1);
      check("t4_rob4", 64'(bus1.wb_rob_idx), 64'd4);
      tick();
      bus1.wb_valid = 1'b0;
      check("t4_rob7_dead_en", 64'(bus1.wb_en), 64'd0);
      check("t4_rob7_present", 64'(bus1.wb_rob_idx), 64'd7);
      tick();
      check("t4_drained_rob", 64'(bus1.wb_rob_idx), 64'd0);
      check("t4_drained_ready", 64'(bus1.in_ready), 64'd1);

      // 4b. same-cycle younger input dropped, older one compacted to head
      bus1.flush = 1'b1;
      bus1.flush_rob_idx = 6'd20;
      bus1.in_valid = 2'b11;
      lane1(0, 6'd25, 6'd1, 32'h25);
      lane1(1, 6'd18, 6'd2, 32'h18);
      tick();
      bus1.flush = 1'b0;
      bus1.in_valid = 2'b00;
      bus1.wb_valid = 1'b1;
      check("t4b_en", 64'(bus1.wb_en), 64'd1);
      check("t4b_rob", 64'(bus1.wb_rob_idx), 64'd18);
      check("t4b_res", 64'(bus1.wb_res), 64'h18);
      tick();
      check("t4b_empty", 64'(bus1.wb_en), 64'd0);
      check("t4b_empty_rob", 64'(bus1.wb_rob_idx), 64'd0);

      // 5. wrap-bit age comparison, then ordering across pointer wraps
      bus1.wb_valid = 1'b0;
      bus1.in_valid = 2'b01;
      lane1(0, 6'b100001, 6'd0, 32'hABCD);
      tick();
      bus1.in_valid = 2'b00;
      bus1.flush = 1'b1;
      bus1.flush_rob_idx = 6'd30;
      tick();
      bus1.flush = 1'b0;
      check("t5_killed_en", 64'(bus1.wb_en), 64'd0);
      check("t5_killed_rob", 64'(bus1.wb_rob_idx), 64'd33);
      tick();
      check("t5_drained", 64'(bus1.wb_rob_idx), 64'd0);
      for (int i = 0; i < 12; i++) begin
         bus1.in_valid = 2'b11;
         lane1(0, 6'(2 * i), 6'd0, 32'(1000 + 2 * i));
         lane1(1, 6'(2 * i + 1), 6'd0, 32'(1001 + 2 * i));
         bus1.wb_valid = 1'b1;
         tick();
         bus1.in_valid = 2'b00;
         check("t5_wrap_a", 64'(bus1.wb_rob_idx), 64'(2 * i));
         check("t5_wrap_a_en", 64'(bus1.wb_en), 64'd1);
         tick();
         check("t5_wrap_b", 64'(bus1.wb_res), 64'(1001 + 2 * i));
         tick();
      end
      check("t5_wrap_empty", 64'(bus1.wb_en), 64'd0);

      // 6. two slots: slot 1 cannot pop while slot 0 stalls
      bus2.in_valid = 2'b11;
      lane2(0, 6'd40, 6'd1, 32'h40);
      lane2(1, 6'd41, 6'd2, 32'h41);
      tick();
      bus2.in_valid = 2'b00;
      check("t6_en", 64'(bus2.wb_en), 64'd3);
      check("t6_rob", 64'(bus2.wb_rob_idx), 64'({6'd41, 6'd40}));
      bus2.wb_valid = 2'b10;
      tick();
      check("t6_nopop_en", 64'(bus2.wb_en), 64'd3);
      check("t6_nopop_rob", 64'(bus2.wb_rob_idx), 64'({6'd41, 6'd40}));
      bus2.wb_valid = 2'b11;
      tick();
      check("t6_bothpop", 64'(bus2.wb_en), 64'd0);
      check("t6_ready", 64'(bus2.in_ready), 64'd1);

      // 7. reset in the middle of a drain
      bus1.wb_valid = 1'b0;
      bus1.in_valid = 2'b11;
      lane1(0, 6'd50, 6'd1, 32'h50);
      lane1(1, 6'd51, 6'd2, 32'h51);
      tick();
      bus1.in_valid = 2'b01;
      lane1(0, 6'd52, 6'd3, 32'h52);
      tick();
      bus1.in_valid = 2'b00;
      bus1.wb_valid = 1'b1;
      tick();
      check("t7_mid_drain", 64'(bus1.wb_rob_idx), 64'd51);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t7_en", 64'(bus1.wb_en), 64'd0);
      check("t7_rob", 64'(bus1.wb_rob_idx), 64'd0);
      check("t7_ready", 64'(bus1.in_ready), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
